// File: rtl/bsg_nonsynth_manycore_io_out_arbiter_pkg.sv
// Shared sizing helpers for the IO-node outgoing packet arbiter.
// Packet geometry mirrors the manycore packet layout.
package bsg_nonsynth_manycore_io_out_arbiter_pkg;

    localparam int unsigned DefAddrWidth = 28;
    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefXCordWidth = 4;
    localparam int unsigned DefYCordWidth = 4;

    localparam int unsigned PktOpWidth = 2;
    localparam int unsigned PktOpExWidth = 4;
    localparam int unsigned PktRegIdWidth = 5;

    function automatic int unsigned safe_clog2(int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // op, op_ex, reg_id, payload, addr, src (x,y), dst (x,y)
    function automatic int unsigned mc_packet_width(int unsigned addr_w, int unsigned data_w,
                                                    int unsigned x_w, int unsigned y_w);
        return PktOpWidth + PktOpExWidth + PktRegIdWidth + data_w + addr_w + 2 * (x_w + y_w);
    endfunction

endpackage

// File: rtl/bsg_nonsynth_manycore_io_out_arbiter_rr_pick.sv
// Round-robin pick: first valid requester after last_i, wrapping modulo num_req_p.
module bsg_nonsynth_manycore_io_out_arbiter_rr_pick #(
    parameter int unsigned num_req_p = 2,
    parameter int unsigned id_width_p = 1
) (
    input  logic [num_req_p-1:0]  v_i,
    input  logic [id_width_p-1:0] last_i,
    output logic [num_req_p-1:0]  grant_o,
    output logic [id_width_p-1:0] id_o,
    output logic                  v_o
);

    always_comb begin
        int unsigned idx;
        grant_o = '0;
        id_o = '0;
        v_o = 1'b0;
        idx = 0;
        for (int unsigned k = 1; k <= num_req_p; k++) begin
            idx = (32'(last_i) + k) % num_req_p;
            for (int unsigned i = 0; i < num_req_p; i++) begin
                if (!v_o && (i == idx) && v_i[i]) begin
                    grant_o[i] = 1'b1;
                    id_o = id_width_p'(i);
                    v_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bsg_nonsynth_manycore_io_out_arbiter.sv
// Shares the IO endpoint's outgoing packet port among num_req_p sources with
// round-robin arbitration, credit gating with a reserve, and a one-entry output register.
module bsg_nonsynth_manycore_io_out_arbiter
    import bsg_nonsynth_manycore_io_out_arbiter_pkg::*;
#(
    parameter int unsigned num_req_p = 2,
    parameter int unsigned addr_width_p = DefAddrWidth,
    parameter int unsigned data_width_p = DefDataWidth,
    parameter int unsigned x_cord_width_p = DefXCordWidth,
    parameter int unsigned y_cord_width_p = DefYCordWidth,
    parameter int unsigned max_out_credits_p = 200,
    parameter int unsigned credit_reserve_p = 1,
    localparam int unsigned credit_counter_width_lp = safe_clog2(max_out_credits_p + 1),
    localparam int unsigned mc_packet_width_lp =
        mc_packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
    localparam int unsigned id_width_lp = safe_clog2(num_req_p)
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic [num_req_p-1:0]                    req_v_i,
    input  logic [num_req_p*mc_packet_width_lp-1:0] req_packet_i,
    output logic [num_req_p-1:0]                    req_ready_o,
    output logic                                    out_v_o,
    output logic [mc_packet_width_lp-1:0]           out_packet_o,
    input  logic                                    out_ready_i,
    input  logic [credit_counter_width_lp-1:0]      out_credits_i,
    input  logic                                    freeze_i,
    output logic [id_width_lp-1:0]                  last_grant_id_o,
    output logic                                    drained_o
);

    localparam int unsigned AvailWidth = credit_counter_width_lp + 1;

    logic                          full_q, full_d;
    logic [mc_packet_width_lp-1:0] pkt_q, pkt_d;
    logic [id_width_lp-1:0]        last_q, last_d;

    logic [num_req_p-1:0]          pick_grant;
    logic [id_width_lp-1:0]        pick_id;
    logic                          pick_v;
    logic                          send, can_accept, credit_ok, grant;
    logic [AvailWidth-1:0]         avail;
    logic [mc_packet_width_lp-1:0] pkt_sel;

    bsg_nonsynth_manycore_io_out_arbiter_rr_pick #(
        .num_req_p (num_req_p),
        .id_width_p(id_width_lp)
    ) u_rr_pick (
        .v_i    (req_v_i),
        .last_i (last_q),
        .grant_o(pick_grant),
        .id_o   (pick_id),
        .v_o    (pick_v)
    );

    assign send = full_q & out_ready_i;
    assign can_accept = ~full_q | send;
    // The held packet's credit is not yet consumed by the endpoint, so count it here.
    assign avail = {1'b0, out_credits_i} - AvailWidth'(full_q);
    assign credit_ok = avail > AvailWidth'(credit_reserve_p);
    assign grant = reset_n_i & can_accept & credit_ok & ~freeze_i & pick_v;

    always_comb begin
        pkt_sel = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (pick_grant[i]) begin
                pkt_sel = req_packet_i[i*mc_packet_width_lp +: mc_packet_width_lp];
            end
        end
    end

    always_comb begin
        full_d = full_q;
        pkt_d = pkt_q;
        last_d = last_q;
        if (grant) begin
            full_d = 1'b1;
            pkt_d = pkt_sel;
            last_d = (num_req_p == 1) ? '0 : pick_id;
        end else if (send) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            full_q <= 1'b0;
            pkt_q <= '0;
            last_q <= id_width_lp'(num_req_p - 1);
        end else begin
            full_q <= full_d;
            pkt_q <= pkt_d;
            last_q <= last_d;
        end
    end

    assign req_ready_o = {num_req_p{grant}} & pick_grant;
    assign out_v_o = full_q;
    assign out_packet_o = pkt_q;
    assign last_grant_id_o = last_q;
    assign drained_o = ~full_q
                     & (out_credits_i == credit_counter_width_lp'(max_out_credits_p));

`ifndef SYNTHESIS
    ready_onehot0_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $onehot0(req_ready_o));
    credits_bound_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        out_credits_i <= credit_counter_width_lp'(max_out_credits_p));
`endif

endmodule
